// File: rtl/bp_pkg.sv
// Shared types and direction-counter constants for the dynamic branch predictor.
package bp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bp_state_e;

    localparam int CTR_BITS_DEFAULT = 2;

    // Counter constants depend on the counter width, so they are computed per instance.
    function automatic int unsigned ctr_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    function automatic int unsigned ctr_weak_t(input int unsigned bits);
        return 32'd1 << (bits - 32'd1);
    endfunction

    function automatic int unsigned ctr_weak_nt(input int unsigned bits);
        return ctr_max(bits) >> 1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down direction counter with set-to-max and load; one per table entry.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_BITS = CTR_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [CTR_BITS-1:0] load_val_i,
    input  logic                set_max_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    localparam logic [CTR_BITS-1:0] CTR_MAX     = CTR_BITS'(ctr_max(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctr_q <= CTR_WEAK_NT;
        end else if (load_i) begin
            ctr_q <= load_val_i;
        end else if (set_max_i) begin
            ctr_q <= CTR_MAX;
        end else if (inc_i && (ctr_q != CTR_MAX)) begin
            ctr_q <= ctr_q + CTR_BITS'(1);
        end else if (dec_i && (ctr_q != '0)) begin
            ctr_q <= ctr_q - CTR_BITS'(1);
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters, EX-stage training,
// mispredict/redirect generation, perf counters and a sequential table invalidate.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int PC_SHIFT = 0,
    parameter int CTR_BITS = CTR_BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_en,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            clear_req,
    output logic            busy,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - PC_SHIFT - IDX;
    localparam logic [CTR_BITS-1:0] CTR_MAX    = CTR_BITS'(ctr_max(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(ctr_weak_t(CTR_BITS));

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr      [ENTRIES];
    bp_state_e           state_q;
    logic [IDX-1:0]      ptr_q;
    logic [31:0]         br_count_q;
    logic [31:0]         mispred_count_q;

    logic [IDX-1:0]   l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit, upd_we, tbl_write;

    assign l_idx = if_pc[PC_SHIFT +: IDX];
    assign l_tag = if_pc[XLEN-1 -: TAG_W];
    assign u_idx = upd_pc[PC_SHIFT +: IDX];
    assign u_tag = upd_pc[XLEN-1 -: TAG_W];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign busy        = (state_q == CLEAR);
    assign pred_taken  = pred_en && !busy && l_hit && ctr[l_idx][CTR_BITS-1];
    assign pred_target = target_q[l_idx];

    assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                       (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + (XLEN'(1) << PC_SHIFT);

    // Updates arriving while the table is being invalidated are dropped.
    assign upd_we    = upd_valid && !busy;
    assign tbl_write = upd_we && (upd_taken || (u_hit && upd_is_jump));

    for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
        logic sel;
        assign sel = upd_we && (u_idx == IDX'(e));
        bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .load_i     (sel && !u_hit && upd_taken),
            .load_val_i (upd_is_jump ? CTR_MAX : CTR_WEAK_T),
            .set_max_i  (sel && u_hit && upd_is_jump),
            .inc_i      (sel && u_hit && !upd_is_jump && upd_taken),
            .dec_i      (sel && u_hit && !upd_is_jump && !upd_taken),
            .ctr_o      (ctr[e])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (busy) begin
            valid_q[ptr_q] <= 1'b0;
        end else if (tbl_write) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                    end
                end
                CLEAR: begin
                    ptr_q <= ptr_q + IDX'(1);
                    if (ptr_q == IDX'(ENTRIES - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else if (upd_valid) begin
            if (br_count_q != '1) br_count_q <= br_count_q + 32'd1;
            if (mispredict && (mispred_count_q != '1)) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: vector table for lookup/training, hand sequences for invalidate,
// reset during invalidate and counter saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pred_en = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_is_jump = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        clear_req = 1'b0;
    logic        busy;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int br_exp = 0;
    int mp_exp = 0;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .PC_SHIFT(0), .CTR_BITS(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .pred_en         (pred_en),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_is_jump     (upd_is_jump),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .clear_req       (clear_req),
        .busy            (busy),
        .br_count        (br_count),
        .mispred_count   (mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic [31:0] ifpc;
        logic        uv;
        logic [31:0] upc;
        logic        uj;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        ept;
        logic [31:0] eptgt;
        logic        emisp;
        logic [31:0] eredir;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic pe, logic [31:0] ifpc, logic uv, logic [31:0] upc,
                                logic uj, logic ut, logic [31:0] utgt, logic upt,
                                logic [31:0] uptgt, logic ept, logic [31:0] eptgt,
                                logic emisp, logic [31:0] eredir);
        vec_t v;
        v.pe = pe; v.ifpc = ifpc; v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut;
        v.utgt = utgt; v.upt = upt; v.uptgt = uptgt; v.ept = ept; v.eptgt = eptgt;
        v.emisp = emisp; v.eredir = eredir;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_upd(input logic uv, input logic [31:0] upc, input logic uj,
                           input logic ut, input logic [31:0] utgt, input logic upt,
                           input logic [31:0] uptgt);
        upd_valid = uv; upd_pc = upc; upd_is_jump = uj; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    endtask

    initial begin
        // pe ifpc  uv upc  uj ut utgt  upt uptgt  ept eptgt  misp redir
        add(1, 32'h10, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0);
        add(1, 32'h10, 1, 32'h10, 0, 1, 32'h40,  0, 32'h0,   0, 32'h0,   1, 32'h40);
        add(1, 32'h10, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h40,  0, 32'h0);
        add(1, 32'h10, 1, 32'h10, 0, 0, 32'h0,   1, 32'h40,  1, 32'h40,  1, 32'h11);
        add(1, 32'h10, 1, 32'h10, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h11);
        add(1, 32'h10, 1, 32'h10, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h11);
        add(1, 32'h10, 1, 32'h10, 0, 1, 32'h40,  0, 32'h0,   0, 32'h0,   1, 32'h40);
        add(1, 32'h10, 1, 32'h10, 0, 1, 32'h44,  1, 32'h40,  0, 32'h0,   1, 32'h44);
        add(0, 32'h10, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0);
        add(1, 32'h10, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h44,  0, 32'h0);
        add(1, 32'h20, 1, 32'h20, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h21);
        add(1, 32'h10, 1, 32'h20, 1, 1, 32'h80,  0, 32'h0,   1, 32'h44,  1, 32'h80);
        add(1, 32'h10, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0);
        add(1, 32'h20, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0);
        add(1, 32'h05, 1, 32'h20, 1, 1, 32'h80,  1, 32'h80,  0, 32'h0,   0, 32'h80);
        add(1, 32'h20, 1, 32'h20, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80);
        add(1, 32'h20, 1, 32'h20, 0, 0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 32'h21);
        add(1, 32'h20, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0);
        add(1, 32'h05, 1, 32'h05, 0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h100);
        add(1, 32'h05, 1, 32'h07, 0, 0, 32'h0,   0, 32'h999, 1, 32'h100, 0, 32'h08);
        add(1, 32'h07, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0);

        // Reset state
        @(negedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_mispred_count", mispred_count, 32'd0);

        // Table-driven lookup / training
        foreach (vecs[i]) begin
            @(negedge clk);
            pred_en = vecs[i].pe;
            if_pc   = vecs[i].ifpc;
            set_upd(vecs[i].uv, vecs[i].upc, vecs[i].uj, vecs[i].ut, vecs[i].utgt,
                    vecs[i].upt, vecs[i].uptgt);
            #1;
            chk($sformatf("v%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].ept));
            if (vecs[i].ept) chk($sformatf("v%0d_pred_target", i), pred_target, vecs[i].eptgt);
            chk($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].emisp));
            if (vecs[i].uv) chk($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].eredir);
            if (vecs[i].uv) br_exp++;
            if (vecs[i].uv && vecs[i].emisp) mp_exp++;
        end
        @(negedge clk);
        set_upd(0, 0, 0, 0, 0, 0, 0);
        pred_en = 1'b1;
        #1;
        chk("tbl_br_count", br_count, 32'(br_exp));
        chk("tbl_mispred_count", mispred_count, 32'(mp_exp));

        // Fill every entry with a correctly predicted jump
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_upd(1, 32'(i), 1, 1, 32'h200 + 32'(i), 1, 32'h200 + 32'(i));
            br_exp++;
        end
        @(negedge clk);
        set_upd(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h3;
        #1;
        chk("fill_pred_taken", 32'(pred_taken), 32'd1);
        chk("fill_pred_target", pred_target, 32'h203);

        // Invalidate: busy exactly 16 cycles, repeated clear_req ignored, update dropped
        clear_req = 1'b1;
        #1;
        chk("clr_busy_k0", 32'(busy), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            clear_req = (k == 2);
            if (k == 4) begin
                set_upd(1, 32'h33, 0, 1, 32'h300, 0, 32'h0);
                br_exp++;
                mp_exp++;
            end else begin
                set_upd(0, 0, 0, 0, 0, 0, 0);
            end
            #1;
            chk($sformatf("clr_busy_k%0d", k), 32'(busy), (k <= 16) ? 32'd1 : 32'd0);
            if (k == 1) chk("clr_pred_forced_off", 32'(pred_taken), 32'd0);
            if (k == 4) begin
                chk("clr_mispredict", 32'(mispredict), 32'd1);
                chk("clr_redirect", redirect_pc, 32'h300);
            end
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if_pc = 32'(i);
            #1;
            chk($sformatf("post_clr_miss_%0d", i), 32'(pred_taken), 32'd0);
        end
        @(negedge clk);
        if_pc = 32'h33;
        #1;
        chk("post_clr_dropped_upd", 32'(pred_taken), 32'd0);
        chk("post_clr_br_count", br_count, 32'(br_exp));
        chk("post_clr_mispred_count", mispred_count, 32'(mp_exp));

        // Reset asserted mid-invalidate
        @(negedge clk);
        set_upd(1, 32'h10, 1, 1, 32'h50, 1, 32'h50);
        @(negedge clk);
        set_upd(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h10;
        #1;
        chk("pre_rst_pred_taken", 32'(pred_taken), 32'd1);
        clear_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            clear_req = 1'b0;
        end
        #1;
        chk("mid_clr_busy", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_br_count", br_count, 32'd0);
        chk("async_rst_mispred_count", mispred_count, 32'd0);
        set_upd(1, 32'h10, 0, 1, 32'h60, 0, 32'h0);
        #1;
        chk("rst_mispredict_live", 32'(mispredict), 32'd1);
        chk("rst_redirect_live", redirect_pc, 32'h60);
        @(negedge clk);
        set_upd(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_pred_taken", 32'(pred_taken), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Counter saturation
        @(negedge clk);
        force dut.br_count_q = 32'hFFFF_FFFF;
        force dut.mispred_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_count_q;
        release dut.mispred_count_q;
        set_upd(1, 32'h10, 0, 1, 32'h70, 0, 32'h0);
        @(negedge clk);
        set_upd(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_br_count", br_count, 32'hFFFF_FFFF);
        chk("sat_mispred_count", mispred_count, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
